// File: rtl/trace_pkg.sv
// Shared types for the write-back trace buffer: FSM state encoding.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x DATA_W, one write port, one registered read port.
// The read register is reset and only loads on a read, so it holds its last
// value between pops; the array itself is never reset.
module trace_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: one sample per cycle at waddr.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Synchronous read port with held output.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: arm, wait for trigger, capture into a circular
// buffer (stop-when-full or ring), then pop entries oldest-first in DONE.
module wb_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              arm,
  input  logic              stop,
  input  logic              mode,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_value,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [1:0]        state
);

  localparam int PTR_W = $clog2(DEPTH);

  state_e           state_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q, rd_valid_q;
  logic             full, trig_hit, we, re;

  // Write/read strobes; arm and rst suppress all buffer activity.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    trig_hit = wb_valid && (!trig_en || (wb_data == trig_value));
    we       = 1'b0;
    re       = 1'b0;
    if (!rst && !arm) begin
      case (state_q)
        // stop in ARMED ends with an empty buffer, so the trigger sample is not kept
        ST_ARMED:   we = trig_hit && !stop;
        ST_CAPTURE: we = wb_valid && !(full && !mode);
        ST_DONE:    re = rd_req && (count_q != '0);
        default:    ;
      endcase
    end
  end

  // Control FSM, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= re;
      if (arm) begin
        state_q    <= ST_ARMED;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (stop) begin
              state_q <= ST_DONE;
              count_q <= '0;
            end
          end
          ST_ARMED: begin
            if (stop) begin
              state_q <= ST_DONE;
              count_q <= '0;
            end else if (trig_hit) begin
              state_q  <= ST_CAPTURE;
              wr_ptr_q <= wr_ptr_q + PTR_W'(1);
              count_q  <= CNT_W'(1);
            end
          end
          ST_CAPTURE: begin
            if (wb_valid) begin
              if (!full) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                count_q  <= count_q + CNT_W'(1);
              end else if (mode) begin
                // ring: newest overwrites oldest, window slides by one
                wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                overflow_q <= 1'b1;
              end else begin
                overflow_q <= 1'b1;
                state_q    <= ST_DONE;
              end
            end
            if (stop) state_q <= ST_DONE;
          end
          ST_DONE: begin
            if (re) begin
              rd_ptr_q <= rd_ptr_q + PTR_W'(1);
              count_q  <= count_q - CNT_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  trace_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(PTR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (wb_data),
    .re    (re),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: table-driven capture scenarios checked against
// a small reference model, plus hand sequences for reset/arm corner cases.
module tb_wb_trace_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wb_valid = 1'b0;
  logic [DW-1:0] wb_data = '0;
  logic          arm = 1'b0, stop = 1'b0, mode = 1'b0, trig_en = 1'b0;
  logic [DW-1:0] trig_value = '0;
  logic          rd_req = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          overflow;
  logic [1:0]    state;

  int tests = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mq[$];

  wb_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_data(wb_data),
    .arm(arm), .stop(stop), .mode(mode), .trig_en(trig_en),
    .trig_value(trig_value), .rd_req(rd_req), .rd_data(rd_data),
    .rd_valid(rd_valid), .count(count), .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rd_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected rd_valid: data 0x%0h, no entry pending", rd_data);
      end else begin
        chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic          mode;
    logic          trig_en;
    logic [DW-1:0] trig;
    int            n;
    logic [DW-1:0] base;
    logic          do_stop;
    int            exp_cnt;
    logic          exp_ovf;
    logic [1:0]    exp_st;
  } vec_t;

  vec_t vecs[6];

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic feed(input logic [DW-1:0] v);
    wb_valid = 1'b1; wb_data = v; tick(); wb_valid = 1'b0;
  endtask

  // Issue n+1 back-to-back reads; only the first n are expected to return data.
  task automatic readout(input int n);
    for (int i = 0; i <= n; i++) begin
      rd_req = 1'b1;
      if (i < mq.size()) exp_q.push_back(mq[i]);
      tick();
    end
    rd_req = 1'b0;
    tick(); tick();
    chk("scoreboard drained", exp_q.size(), 0);
    chk("count after readout", int'(count), 0);
    if (mq.size() > 0) chk("rd_data held", int'(rd_data), int'(mq[mq.size()-1]));
  endtask

  // Reference model of what the buffer should hold after a sample stream.
  task automatic model(input vec_t v);
    logic armed;
    logic [DW-1:0] s;
    armed = 1'b1;
    mq.delete();
    for (int i = 0; i < v.n; i++) begin
      s = v.base + DW'(i);
      if (armed) begin
        if (!v.trig_en || s == v.trig) begin
          armed = 1'b0;
          mq.push_back(s);
        end
      end else if (mq.size() == DEPTH) begin
        if (!v.mode) break;
        void'(mq.pop_front());
        mq.push_back(s);
      end else begin
        mq.push_back(s);
      end
    end
  endtask

  initial begin
    //         mode  trig_en trig      n   base     stop  cnt ovf   state
    vecs[0] = '{1'b0, 1'b0, 16'h0000,  5, 16'h0011, 1'b1, 5, 1'b0, 2'd3};
    vecs[1] = '{1'b0, 1'b0, 16'h0000,  9, 16'h0000, 1'b0, 8, 1'b1, 2'd3};
    vecs[2] = '{1'b1, 1'b0, 16'h0000, 10, 16'h0000, 1'b1, 8, 1'b1, 2'd3};
    vecs[3] = '{1'b0, 1'b1, 16'h0023,  6, 16'h0020, 1'b1, 3, 1'b0, 2'd3};
    vecs[4] = '{1'b1, 1'b0, 16'h0000,  8, 16'h0040, 1'b0, 8, 1'b0, 2'd2};
    vecs[5] = '{1'b0, 1'b1, 16'h0099,  4, 16'h0000, 1'b1, 0, 1'b0, 2'd3};

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("reset state", int'(state), 0);
    chk("reset count", int'(count), 0);
    chk("reset overflow", int'(overflow), 0);
    chk("reset rd_valid", int'(rd_valid), 0);
    chk("reset rd_data", int'(rd_data), 0);

    // Reads in IDLE are ignored (monitor flags any rd_valid)
    rd_req = 1'b1; tick(); rd_req = 1'b0; tick();
    chk("idle read state", int'(state), 0);

    // Table-driven capture scenarios
    for (int v = 0; v < 6; v++) begin
      mode = vecs[v].mode;
      trig_en = vecs[v].trig_en;
      trig_value = vecs[v].trig;
      do_arm();
      chk("armed state", int'(state), 1);
      for (int i = 0; i < vecs[v].n; i++) feed(vecs[v].base + DW'(i));
      if (vecs[v].do_stop) do_stop();
      chk($sformatf("vec%0d state", v), int'(state), int'(vecs[v].exp_st));
      chk($sformatf("vec%0d count", v), int'(count), vecs[v].exp_cnt);
      chk($sformatf("vec%0d overflow", v), int'(overflow), int'(vecs[v].exp_ovf));
      do_stop();
      model(vecs[v]);
      readout(vecs[v].exp_cnt);
    end

    // Trigger on 0xDEAD in stream 1,2,DEAD,3
    mode = 1'b0; trig_en = 1'b1; trig_value = 16'hDEAD;
    do_arm();
    feed(16'h0001); feed(16'h0002); feed(16'hDEAD); feed(16'h0003);
    do_stop();
    chk("trig count", int'(count), 2);
    mq.delete(); mq.push_back(16'hDEAD); mq.push_back(16'h0003);
    readout(2);

    // Sample and stop in the same cycle: sample is kept
    trig_en = 1'b0;
    do_arm();
    feed(16'h0050);
    wb_valid = 1'b1; wb_data = 16'h0051; stop = 1'b1; tick();
    wb_valid = 1'b0; stop = 1'b0;
    chk("stop+sample state", int'(state), 3);
    chk("stop+sample count", int'(count), 2);
    mq.delete(); mq.push_back(16'h0050); mq.push_back(16'h0051);
    readout(2);

    // Reset during readout with count=4
    do_arm();
    for (int i = 0; i < 6; i++) feed(16'h0060 + DW'(i));
    do_stop();
    exp_q.push_back(16'h0060); rd_req = 1'b1; tick();
    exp_q.push_back(16'h0061); tick();
    chk("pre-reset count", int'(count), 4);
    rst = 1'b1; tick(); rst = 1'b0; rd_req = 1'b0;
    chk("rst state", int'(state), 0);
    chk("rst count", int'(count), 0);
    chk("rst rd_valid", int'(rd_valid), 0);
    chk("rst rd_data", int'(rd_data), 0);
    rd_req = 1'b1; tick(); rd_req = 1'b0; tick();
    chk("post-rst read ignored", int'(count), 0);
    chk("post-rst scoreboard", exp_q.size(), 0);

    // Overflowed ring, then arm+stop in CAPTURE with count=3
    mode = 1'b1;
    do_arm();
    for (int i = 0; i < 10; i++) feed(DW'(i));
    do_arm();
    chk("re-arm overflow clear", int'(overflow), 0);
    mode = 1'b0;
    feed(16'h0070); feed(16'h0071); feed(16'h0072);
    chk("capture count 3", int'(count), 3);
    arm = 1'b1; stop = 1'b1; tick(); arm = 1'b0; stop = 1'b0;
    chk("arm+stop state", int'(state), 1);
    chk("arm+stop count", int'(count), 0);
    chk("arm+stop overflow", int'(overflow), 0);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    errors++;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $fatal(1);
  end

endmodule
